// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card shoe using an external RNG, with retry and linear-scan fallback.
// Optional CARD_DEALER_STATS_EN adds rejection and scan-usage counters.
module card_dealer #(
   parameter int unsigned IDX_WIDTH = 6,
   parameter int unsigned MAX_RETRY = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_deal,
   input  logic                 i_shuffle,
   output logic                 o_rng_request,
   output logic [IDX_WIDTH-1:0] o_rng_max,
   input  logic [IDX_WIDTH-1:0] i_rng_value,
   output logic                 o_card_valid,
   output logic [3:0]           o_card_rank,
   output logic [1:0]           o_card_suit,
   output logic [5:0]           o_cards_left,
   output logic                 o_busy,
   output logic                 o_deal_error
`ifdef CARD_DEALER_STATS_EN
   ,
   output logic [15:0]          o_retry_total,
   output logic [7:0]           o_scan_count
`endif
);

   localparam int unsigned NUM_CARDS = 52;
   localparam int unsigned LAST_CARD = 51;
   localparam int unsigned CARD_W    = 6;
   localparam int unsigned RETRY_W   = 8;
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_CAPTURE,
      S_CHECK,
      S_SCAN,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_CARDS-1:0]   used_q, used_d;
   logic [IDX_WIDTH-1:0]   idx_q, idx_d;
   logic [CARD_W-1:0]      ptr_q, ptr_d;
   logic [RETRY_W-1:0]     retry_q, retry_d;
   logic [5:0]             cards_left_q, cards_left_d;
   logic                   card_valid_q, card_valid_d;
   logic [3:0]             rank_q, rank_d;
   logic [1:0]             suit_q, suit_d;
   logic                   busy_q, busy_d;
   logic                   deal_error_q, deal_error_d;
   logic                   rng_request_q, rng_request_d;

   logic [CARD_W-1:0]      idx_card_c;
   logic                   idx_in_range_c;
   logic                   check_hit_c;
   logic                   cmd_ok_c;
   logic                   shuffle_take_c;
   logic [RETRY_W-1:0]     retry_inc_c;
   logic [CARD_W-1:0]      base_c;
   logic [1:0]             suit_c;
   logic [3:0]             rank_c;

   assign idx_card_c     = CARD_W'(idx_q);
   assign idx_in_range_c = (idx_q <= IDX_WIDTH'(LAST_CARD));
   assign check_hit_c    = idx_in_range_c && !used_q[idx_card_c];
   assign cmd_ok_c       = (state_q == S_IDLE) && !busy_q;
   assign shuffle_take_c = cmd_ok_c && i_shuffle;
   assign retry_inc_c    = retry_q + RETRY_W'(1);

   // Index to rank/suit: suit selects a block of 13, rank is the offset within it.
   always_comb begin
      suit_c = 2'd0;
      base_c = CARD_W'(0);
      if (idx_card_c >= CARD_W'(39)) begin
         suit_c = 2'd3;
         base_c = CARD_W'(39);
      end else if (idx_card_c >= CARD_W'(26)) begin
         suit_c = 2'd2;
         base_c = CARD_W'(26);
      end else if (idx_card_c >= CARD_W'(13)) begin
         suit_c = 2'd1;
         base_c = CARD_W'(13);
      end
      rank_c = 4'(idx_card_c - base_c) + 4'd1;
   end

   always_comb begin
      state_d       = state_q;
      used_d        = used_q;
      idx_d         = idx_q;
      ptr_d         = ptr_q;
      retry_d       = retry_q;
      cards_left_d  = cards_left_q;
      rank_d        = rank_q;
      suit_d        = suit_q;
      card_valid_d  = 1'b0;
      deal_error_d  = 1'b0;
      rng_request_d = (state_q == S_REQ);
      busy_d        = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (shuffle_take_c) begin
               used_d       = '0;
               cards_left_d = 6'(NUM_CARDS);
            end else if (cmd_ok_c && i_deal) begin
               if (cards_left_q == 6'd0) begin
                  deal_error_d = 1'b1;
               end else begin
                  retry_d = '0;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            idx_d   = i_rng_value;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (check_hit_c) begin
               used_d[idx_card_c] = 1'b1;
               state_d            = S_DONE;
            end else begin
               retry_d = retry_inc_c;
               if (retry_inc_c == RETRY_LIMIT) begin
                  ptr_d   = idx_in_range_c ? idx_card_c : CARD_W'(0);
                  state_d = S_SCAN;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         // Termination relies on at least one free card, guaranteed by the IDLE check.
         S_SCAN: begin
            if (!used_q[ptr_q]) begin
               idx_d         = IDX_WIDTH'(ptr_q);
               used_d[ptr_q] = 1'b1;
               state_d       = S_DONE;
            end else begin
               ptr_d = (ptr_q == CARD_W'(LAST_CARD)) ? CARD_W'(0) : ptr_q + CARD_W'(1);
            end
         end
         S_DONE: begin
            card_valid_d = 1'b1;
            rank_d       = rank_c;
            suit_d       = suit_c;
            cards_left_d = cards_left_q - 6'd1;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         used_q        <= '0;
         idx_q         <= '0;
         ptr_q         <= '0;
         retry_q       <= '0;
         cards_left_q  <= 6'(NUM_CARDS);
         card_valid_q  <= 1'b0;
         rank_q        <= 4'd0;
         suit_q        <= 2'd0;
         busy_q        <= 1'b0;
         deal_error_q  <= 1'b0;
         rng_request_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         used_q        <= used_d;
         idx_q         <= idx_d;
         ptr_q         <= ptr_d;
         retry_q       <= retry_d;
         cards_left_q  <= cards_left_d;
         card_valid_q  <= card_valid_d;
         rank_q        <= rank_d;
         suit_q        <= suit_d;
         busy_q        <= busy_d;
         deal_error_q  <= deal_error_d;
         rng_request_q <= rng_request_d;
      end
   end

   assign o_rng_request = rng_request_q;
   assign o_rng_max     = IDX_WIDTH'(LAST_CARD);
   assign o_card_valid  = card_valid_q;
   assign o_card_rank   = rank_q;
   assign o_card_suit   = suit_q;
   assign o_cards_left  = cards_left_q;
   assign o_busy        = busy_q;
   assign o_deal_error  = deal_error_q;

`ifdef CARD_DEALER_STATS_EN
   logic [15:0] retry_total_q, retry_total_d;
   logic [7:0]  scan_count_q, scan_count_d;
   logic        check_reject_c;

   assign check_reject_c = (state_q == S_CHECK) && !check_hit_c;

   // Saturating statistics, cleared together with the deck.
   always_comb begin
      retry_total_d = retry_total_q;
      scan_count_d  = scan_count_q;
      if (shuffle_take_c) begin
         retry_total_d = '0;
         scan_count_d  = '0;
      end else if (check_reject_c) begin
         if (retry_total_q != 16'hFFFF) begin
            retry_total_d = retry_total_q + 16'd1;
         end
         if ((retry_inc_c == RETRY_LIMIT) && (scan_count_q != 8'hFF)) begin
            scan_count_d = scan_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         retry_total_q <= '0;
         scan_count_q  <= '0;
      end else begin
         retry_total_q <= retry_total_d;
         scan_count_q  <= scan_count_d;
      end
   end

   assign o_retry_total = retry_total_q;
   assign o_scan_count  = scan_count_q;
`endif

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Consumer side of the random-value request interface. Issues request pulses to the random number generator and captures the returned index.
- Rejects indices already dealt or out of range, and returns one unique card (rank/suit) per deal request from a 52-card shoe.
- Sits between the game control FSM and the random number generator.
- Tracks dealt cards in a 52-bit used mask; a shuffle restores the full deck.

Parameters:
- IDX_WIDTH, 6, width of card index and RNG value bus (must hold 0..51 and the RNG max)
- MAX_RETRY, 8, consecutive rejected RNG values before falling back to a linear scan (1..255)

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_deal  input  1  request one card; sampled only in IDLE
- i_shuffle  input  1  return all cards to deck; sampled only in IDLE
- o_rng_request  output  1  request strobe to RNG (RNG latches on rising edge)
- o_rng_max  output  IDX_WIDTH  constant 51, RNG wrap value
- i_rng_value  input  IDX_WIDTH  value returned by RNG
- o_card_valid  output  1  one-cycle strobe; card outputs valid this cycle
- o_card_rank  output  4  1..13 (1=ace, 11..13=J,Q,K)
- o_card_suit  output  2  0..3
- o_cards_left  output  6  undealt cards, 0..52
- o_busy  output  1  high in any state other than IDLE
- o_deal_error  output  1  one-cycle strobe: deal requested with empty deck

Behaviour:
- Reset (synchronous, i_reset high at clock edge):
  - state=IDLE; used mask cleared; o_cards_left=52.
  - o_card_valid, o_rng_request, o_busy, o_deal_error all 0.
  - o_card_rank=0, o_card_suit=0; retry count=0.
  - Reset asserted mid-operation aborts the deal: no o_card_valid, mask cleared.
- All outputs are registered. o_rng_max is tied to 51.
- IDLE:
  - i_shuffle=1 → clear mask, cards_left=52, stay IDLE. Shuffle has priority over a same-cycle i_deal; that deal is dropped.
  - i_deal=1 and cards_left=0 → o_deal_error=1 for the next cycle; stay IDLE; no RNG request.
  - i_deal=1 and cards_left>0 → retry=0, go to REQ.
- REQ: o_rng_request=1 for exactly this one cycle → CAPTURE.
- CAPTURE: o_rng_request=0; register i_rng_value into idx → CHECK.
- CHECK:
  - idx≤51 and used[idx]=0 → set used[idx] → DONE.
  - Otherwise retry=retry+1.
    - If the new retry equals MAX_RETRY → SCAN with ptr = idx if idx≤51, else 0.
    - Else → REQ.
- SCAN: one mask entry per cycle.
  - used[ptr]=0 → idx=ptr, set used[ptr] → DONE.
  - Else ptr = (ptr==51) ? 0 : ptr+1 (wrap-around).
  - Termination is guaranteed because cards_left>0. Worst case 52 cycles.
- DONE:
  - o_card_valid=1; o_card_rank = idx mod 13 + 1; o_card_suit = idx / 13.
  - cards_left decrements by 1 → IDLE.
  - Rank/suit hold their value until the next DONE.
- i_deal and i_shuffle are ignored while o_busy=1 (no queuing).
- Latency: i_deal sampled at edge T with first RNG value accepted → o_card_valid high in cycle T+4. Each retry adds 3 cycles.

Optional Feature:
- Macro: CARD_DEALER_STATS_EN.
- Defined:
  - Adds output o_retry_total (16 bits): total CHECK rejections since the last shuffle or reset, saturating at 16'hFFFF.
  - Adds output o_scan_count (8 bits): number of deals that used SCAN, saturating at 8'hFF.
  - Both outputs clear on reset and on an accepted shuffle.
- Undefined: neither port exists and no counter logic is generated. Core behaviour is identical in both builds.

Test Plan:
- Reset for 2 cycles → o_cards_left=52; o_busy=0, o_rng_request=0, o_card_valid=0, o_deal_error=0.
- Single deal at T, stub RNG returns 0 → o_rng_request high only at T+1; o_card_valid high only at T+4 with rank=1, suit=0; o_cards_left=51.
- Deal after card 0 is dealt; stub returns 0 then 14 → two o_rng_request pulses; o_card_valid at T+7 with rank=2, suit=1; cards_left=50.
- MAX_RETRY=8, card 0 dealt, stub stuck at 60 → exactly 8 request pulses, then SCAN from 0 skips 0 and deals idx 1 (rank=2, suit=0); o_busy drops the cycle after o_card_valid.
- Deal all 52 cards (stub counting 0..51) → all rank/suit pairs unique, cards_left=0. 53rd i_deal → o_deal_error pulse, no request. i_shuffle with i_deal in the same cycle → cards_left=52, no deal starts.
- i_reset asserted while in CHECK → next cycle IDLE, cards_left=52, no o_card_valid. With CARD_DEALER_STATS_EN defined, o_retry_total=0 after reset.
